// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the register-register ALU control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB = 4'b0010,
    ALU_AND = 4'b0011, ALU_OR  = 4'b0100, ALU_ROR = 4'b0101,
    ALU_ROL = 4'b0110, ALU_SHR = 4'b0111, ALU_SHL = 4'b1000
  } alu_op_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_SHR = 5'b01001;
  localparam logic [4:0] OP_SHL = 5'b01010;

  localparam int IR_OP_HI = 31;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  // ALU_NOP doubles as the "unsupported opcode" marker.
  function automatic alu_op_t decode_op(input logic [4:0] opcode);
    case (opcode)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Turns a 4-bit register index plus enable into a one-hot (or zero) select.
module reg_sel_decoder #(
  parameter int NREG = 16
) (
  input  logic [3:0]      idx,
  input  logic            en,
  output logic [NREG-1:0] sel
);

  // Indices at or beyond NREG match no bit and so decode to zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sel[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Hardwired T0-T5 control sequencer for register-register ALU instructions.
//   state   | meaning
//   IDLE    | waiting for run
//   T0      | PC to MAR, PC+1 into Z
//   T1      | Z to PC (first cycle only), memory read into MDR until mem_ready
//   T2      | MDR to IR
//   T3      | decode; rb onto bus into Y, or FAULT on unsupported opcode
//   T4      | rc onto bus, ALU result into Z
//   T5      | Z to ra
//   FAULT   | sticky unsupported-opcode trap, cleared only by reset
module alu_rr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zlowin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            IncPC,
  output logic            Read,
  output logic [3:0]      alu_op,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            fault
);

  state_t         state;
  logic           t1_wait;
  logic [OPW-1:0] opcode;
  alu_op_t        op;
  logic           op_ok;
  logic           rin_en;
  logic           rout_en;
  logic [3:0]     rout_idx;
  logic           unused_ir;

  assign opcode    = ir[IR_OP_HI -: OPW];
  assign op        = decode_op(opcode);
  assign op_ok     = (op != ALU_NOP);
  assign unused_ir = ^ir[IR_RC_LO-1:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      t1_wait <= 1'b0;
    end else begin
      t1_wait <= 1'b0;
      case (state)
        S_IDLE:  if (run) state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1: begin
          if (mem_ready) state <= S_T2;
          else           t1_wait <= 1'b1;
        end
        S_T2:    state <= S_T3;
        S_T3:    state <= op_ok ? S_T4 : S_FAULT;
        S_T4:    state <= S_T5;
        S_T5:    state <= run ? S_T0 : S_IDLE;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and the (stable after T2) IR only.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zlowin  = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    alu_op  = ALU_NOP;
    case (state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = !t1_wait;
        PCin    = !t1_wait;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: Yin = op_ok;
      S_T4: begin
        Zlowin = 1'b1;
        alu_op = op;
      end
      S_T5: Zlowout = 1'b1;
      default: ;
    endcase
  end

  assign fault    = (state == S_FAULT);
  assign rin_en   = (state == S_T5);
  assign rout_en  = ((state == S_T3) && op_ok) || (state == S_T4);
  assign rout_idx = (state == S_T3) ? ir[IR_RB_HI:IR_RB_LO] : ir[IR_RC_HI:IR_RC_LO];

  reg_sel_decoder #(.NREG(NREG)) u_rin_dec (
    .idx (ir[IR_RA_HI:IR_RA_LO]),
    .en  (rin_en),
    .sel (rin)
  );

  reg_sel_decoder #(.NREG(NREG)) u_rout_dec (
    .idx (rout_idx),
    .en  (rout_en),
    .sel (rout)
  );

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Hardwired control unit that drives the DataPath control strobes for register-register ALU instructions (add, sub, and, or, ror, rol, shr, shl).
- Generates the T0–T5 fetch/execute step sequence from the IR contents and a memory-ready handshake.
- Sits beside DataPath; its outputs connect one-for-one to the DataPath control inputs.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- NREG, 16, register count; sets the width of rin/rout.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset.
- run  in  1  level; permits leaving IDLE and continuing past T5.
- ir  in  32  current IR contents from DataPath.
- mem_ready  in  1  memory read data valid.
- PCout, Zlowout, MDRout  out  1  bus drive strobes.
- MARin, Zlowin, PCin, MDRin, IRin, Yin  out  1  register load strobes.
- IncPC  out  1  ALU increments PC operand.
- Read  out  1  memory read / MDR mux select.
- alu_op  out  4  ALU function select.
- rin  out  NREG  one-hot register load enables.
- rout  out  NREG  one-hot register bus drive.
- fault  out  1  sticky unsupported-opcode flag.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, FAULT. State is registered.
- Moore outputs: all outputs are decoded from state (plus ir fields) only; no mem_ready-to-output path.
- Reset (clear=0, any time, including mid-instruction): state=IDLE; all strobes, rin, rout = 0; alu_op = ALU_NOP; fault = 0.
- IDLE: all outputs 0. run=1 -> T0; otherwise stay in IDLE.
- T0: PCout, MARin, IncPC, Zlowin = 1. Next state T1.
- T1: Zlowout, PCin, Read, MDRin = 1.
  - mem_ready=1 -> T2.
  - mem_ready=0 -> stay in T1 with Read/MDRin held.
  - PCin/Zlowout are asserted only on the first T1 cycle: a wait flag suppresses them on repeat cycles so PC is not re-loaded.
- T2: MDRout, IRin = 1. Next state T3.
- T3 (ir now valid):
  - Decode opcode = ir[31:27]. Unsupported opcode -> FAULT, with no strobes asserted this cycle.
  - Otherwise rout[rb] = 1 and Yin = 1, with rb = ir[22:19]; next state T4.
- T4: rout[rc] = 1 (rc = ir[18:15]), Zlowin = 1, alu_op = decoded op. Next state T5.
- T5: Zlowout = 1, rin[ra] = 1 (ra = ir[26:23]). run=1 -> T0; run=0 -> IDLE.
- FAULT: fault = 1; all strobes 0; leaves only on reset.
- Register index decode:
  - Indices at or above NREG decode to all-zero rin/rout.
  - ra = rb = rc is legal.
- rin and rout are one-hot or zero at all times. Never more than one bus driver (PCout, Zlowout, MDRout, rout) per cycle.
- Instruction latency is 6 cycles plus (mem_ready wait cycles).

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum;
  - opcodes: ADD=00011, SUB=00100, AND=00101, OR=00110, ROR=00111, ROL=01000, SHR=01001, SHL=01010;
  - alu_op codes: NOP=0000, ADD=0001, SUB=0010, AND=0011, OR=0100, ROR=0101, ROL=0110, SHR=0111, SHL=1000;
  - IR field bit positions.
- One sub-module, reg_sel_decoder: converts a 4-bit index plus enable into NREG one-hot; instantiated twice, for rin and rout.

Test Plan:
- Reset then run=1, ir=0x38918000 (ror r1,r2,r3), mem_ready=1 -> T0..T5 in 6 cycles; T3 rout=0x0004 and Yin=1; T4 rout=0x0008, alu_op=0101, Zlowin=1; T5 rin=0x0002, Zlowout=1.
- Same instruction with mem_ready low for 3 cycles -> T1 lasts 4 cycles; PCin high only in the first; Read/MDRin high in all 4; T2 follows on the cycle after mem_ready rises.
- Opcode sweep over all 8 supported opcodes -> alu_op in T4 matches the package table.
- ir[31:27]=11111 -> FAULT entered after T3; fault=1 sticky; no strobes asserted; clear low clears it to IDLE.
- clear pulsed low during T4 -> immediately IDLE with all outputs 0 and no rin pulse; restart from T0 after clear high and run=1.
- run=0 sampled in T5 -> IDLE after T5, outputs 0; run=1 -> T0 next cycle. One-hot/zero and single-bus-driver checks asserted throughout all scenarios.
